// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the front-panel time/date setting controller:
// edit state encoding, field indices, per-field ranges, 48-bit packing
// offsets and the days-in-month helper.
package time_set_pkg;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SEL_YR = 3'd1,
        SEL_MO = 3'd2,
        SEL_DY = 3'd3,
        SEL_HR = 3'd4,
        SEL_MI = 3'd5,
        SEL_SE = 3'd6,
        COMMIT = 3'd7
    } tsc_state_t;

    // Field indices as seen on edit_field; FLD_NONE means "not editing".
    localparam logic [2:0] FLD_YR   = 3'd0;
    localparam logic [2:0] FLD_MO   = 3'd1;
    localparam logic [2:0] FLD_DY   = 3'd2;
    localparam logic [2:0] FLD_HR   = 3'd3;
    localparam logic [2:0] FLD_MI   = 3'd4;
    localparam logic [2:0] FLD_SE   = 3'd5;
    localparam logic [2:0] FLD_NONE = 3'd7;
    localparam int         NUM_FIELDS = 6;

    // Key bit positions on sw_in.
    localparam int KEY_MODE = 0;
    localparam int KEY_UP   = 1;
    localparam int KEY_DOWN = 2;
    localparam int KEY_OK   = 3;
    localparam int NUM_KEYS = 4;

    // Per-field limits (day upper bound is refined by days_in_month).
    localparam logic [7:0] YR_MIN = 8'd0;
    localparam logic [7:0] YR_MAX = 8'd99;
    localparam logic [7:0] MO_MIN = 8'd1;
    localparam logic [7:0] MO_MAX = 8'd12;
    localparam logic [7:0] DY_MIN = 8'd1;
    localparam logic [7:0] DY_MAX = 8'd31;
    localparam logic [7:0] HR_MIN = 8'd0;
    localparam logic [7:0] HR_MAX = 8'd23;
    localparam logic [7:0] MI_MIN = 8'd0;
    localparam logic [7:0] MI_MAX = 8'd59;
    localparam logic [7:0] SE_MIN = 8'd0;
    localparam logic [7:0] SE_MAX = 8'd59;

    // Power-up value: year 0 (2000), January 1st, 00:00:00.
    localparam logic [47:0] TIME_RESET = {8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0};

    // LSB of field f inside the packed {yr,mo,dy,hr,mi,se} word.
    function automatic int field_lsb(input int f);
        return 40 - 8 * f;
    endfunction

    function automatic logic [7:0] field_min(input logic [2:0] f);
        logic [7:0] v;
        case (f)
            FLD_YR:  v = YR_MIN;
            FLD_MO:  v = MO_MIN;
            FLD_DY:  v = DY_MIN;
            FLD_HR:  v = HR_MIN;
            FLD_MI:  v = MI_MIN;
            default: v = SE_MIN;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] field_max(input logic [2:0] f);
        logic [7:0] v;
        case (f)
            FLD_YR:  v = YR_MAX;
            FLD_MO:  v = MO_MAX;
            FLD_DY:  v = DY_MAX;
            FLD_HR:  v = HR_MAX;
            FLD_MI:  v = MI_MAX;
            default: v = SE_MAX;
        endcase
        return v;
    endfunction

    // Year is an offset from 2000, so every multiple of 4 is a leap year.
    function automatic logic [7:0] days_in_month(input logic [7:0] year,
                                                 input logic [7:0] month);
        logic [7:0] dim;
        case (month)
            8'd2:                    dim = ((year % 8'd4) == 8'd0) ? 8'd29 : 8'd28;
            8'd4, 8'd6, 8'd9, 8'd11: dim = 8'd30;
            default:                 dim = 8'd31;
        endcase
        return dim;
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Bundle of the controller's panel, counter and display signals.
// slave = the controller, master = whatever drives keys/time and consumes results.
interface time_set_ctrl_if;
    logic        en_1hz;
    logic [3:0]  sw_in;
    logic [47:0] cur_time;
    logic        set_time;
    logic [47:0] bin_time;
    logic        edit_active;
    logic [2:0]  edit_field;
    logic [47:0] edit_time;
    logic [5:0]  blank_mask;

    modport master (
        output en_1hz, sw_in, cur_time,
        input  set_time, bin_time, edit_active, edit_field, edit_time, blank_mask
    );

    modport slave (
        input  en_1hz, sw_in, cur_time,
        output set_time, bin_time, edit_active, edit_field, edit_time, blank_mask
    );
endinterface

// File: rtl/time_set_ctrl_key_debounce.sv
// One key: 2-FF synchroniser, stability counter, one-cycle pulse on the
// accepted rising edge. Releases are debounced too but raise no event.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_press
);
    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;

    logic [1:0]       sync_reg;
    logic             stable_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             press_reg;

    // Count consecutive samples differing from the accepted level; accept on the Nth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg   <= 2'b00;
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
            press_reg  <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], key_raw};
            press_reg <= 1'b0;
            if (sync_reg[1] == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(DEBOUNCE_CYC - 1)) begin
                stable_reg <= sync_reg[1];
                cnt_reg    <= '0;
                press_reg  <= sync_reg[1];
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign key_press = press_reg;
endmodule

// File: rtl/time_set_ctrl.sv
// Front-panel time/date setting controller. Debounces the MODE/UP/DOWN/OK
// keys, edits a snapshot of the live time field by field, and loads the
// date/time counter with a one-cycle set_time strobe on confirm.
// Optional macro TSC_BLINK_EN: blink the field under edit via blank_mask.
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int TIMEOUT_S    = 30
) (
    input  logic            clk,
    input  logic            rst,
    time_set_ctrl_if.slave  bus
);
    localparam int TICK_W = $clog2(TIMEOUT_S + 1);

    logic [NUM_KEYS-1:0] press_vec;
    logic                any_press;
    logic                ok_win, mode_win, up_win, down_win;

    tsc_state_t          state_reg;
    logic [47:0]         edit_time_reg;
    logic [47:0]         bin_time_reg;
    logic [2:0]          edit_field_reg;
    logic                edit_active_reg;
    logic                set_time_reg;
    logic [TICK_W-1:0]   tick_reg;

    logic [7:0]          fld_cur [NUM_FIELDS];
    logic [7:0]          fld_new [NUM_FIELDS];
    logic [7:0]          step_cur, step_lo, step_hi, step_new, step_dim;
    logic [47:0]         step_time;
    logic [5:0]          blank_mask_w;

    genvar gi;

    // One debouncer per key.
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_debounce (
                .clk       (clk),
                .rst       (rst),
                .key_raw   (bus.sw_in[gi]),
                .key_press (press_vec[gi])
            );
        end
    endgenerate

    // Same-cycle presses resolve OK > MODE > UP > DOWN; any press still resets the timeout.
    assign any_press = |press_vec;
    assign ok_win    = press_vec[KEY_OK];
    assign mode_win  = press_vec[KEY_MODE] & ~press_vec[KEY_OK];
    assign up_win    = press_vec[KEY_UP]   & ~press_vec[KEY_OK] & ~press_vec[KEY_MODE];
    assign down_win  = press_vec[KEY_DOWN] & ~press_vec[KEY_OK] & ~press_vec[KEY_MODE]
                     & ~press_vec[KEY_UP];

    // Unpack the working copy into per-field bytes.
    generate
        for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_unpack
            assign fld_cur[gi] = edit_time_reg[field_lsb(gi) +: 8];
        end
    endgenerate

    // Next working copy for an UP/DOWN step on the selected field, with day clamping.
    always_comb begin
        step_cur = 8'd0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (edit_field_reg == 3'(i)) step_cur = fld_cur[i];
        end
        step_lo = field_min(edit_field_reg);
        step_hi = (edit_field_reg == FLD_DY) ? days_in_month(fld_cur[FLD_YR], fld_cur[FLD_MO])
                                             : field_max(edit_field_reg);
        if (up_win) step_new = (step_cur >= step_hi) ? step_lo : step_cur + 8'd1;
        else        step_new = (step_cur <= step_lo) ? step_hi : step_cur - 8'd1;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            fld_new[i] = (edit_field_reg == 3'(i)) ? step_new : fld_cur[i];
        end
        // A shorter month (or a non-leap February) pulls the day down with it.
        step_dim = days_in_month(fld_new[FLD_YR], fld_new[FLD_MO]);
        if ((edit_field_reg == FLD_YR || edit_field_reg == FLD_MO) && fld_new[FLD_DY] > step_dim)
            fld_new[FLD_DY] = step_dim;
        step_time = {fld_new[0], fld_new[1], fld_new[2], fld_new[3], fld_new[4], fld_new[5]};
    end

    // Edit state machine with registered outputs and the inactivity timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= RUN;
            edit_time_reg   <= TIME_RESET;
            bin_time_reg    <= TIME_RESET;
            edit_field_reg  <= FLD_NONE;
            edit_active_reg <= 1'b0;
            set_time_reg    <= 1'b0;
            tick_reg        <= '0;
        end else begin
            set_time_reg <= 1'b0;
            case (state_reg)
                RUN: begin
                    if (mode_win) begin
                        edit_time_reg   <= bus.cur_time;
                        state_reg       <= SEL_YR;
                        edit_field_reg  <= FLD_YR;
                        edit_active_reg <= 1'b1;
                        tick_reg        <= '0;
                    end
                end
                COMMIT: begin
                    state_reg       <= RUN;
                    edit_field_reg  <= FLD_NONE;
                    edit_active_reg <= 1'b0;
                end
                default: begin
                    if (ok_win) begin
                        state_reg    <= COMMIT;
                        set_time_reg <= 1'b1;
                        bin_time_reg <= edit_time_reg;
                        tick_reg     <= '0;
                    end else if (mode_win) begin
                        state_reg      <= (state_reg == SEL_SE) ? SEL_YR
                                                                : tsc_state_t'(state_reg + 3'd1);
                        edit_field_reg <= (edit_field_reg == FLD_SE) ? FLD_YR
                                                                     : edit_field_reg + 3'd1;
                        tick_reg       <= '0;
                    end else if (up_win || down_win) begin
                        edit_time_reg <= step_time;
                        tick_reg      <= '0;
                    end else if (any_press) begin
                        tick_reg <= '0;
                    end else if (bus.en_1hz) begin
                        if (tick_reg == TICK_W'(TIMEOUT_S - 1)) begin
                            state_reg       <= RUN;
                            edit_field_reg  <= FLD_NONE;
                            edit_active_reg <= 1'b0;
                            tick_reg        <= '0;
                        end else begin
                            tick_reg <= tick_reg + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef TSC_BLINK_EN
    logic blink_reg;

    // Blink phase: toggles each second while editing, restarts dark on any press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_reg <= 1'b0;
        end else if (any_press || !edit_active_reg) begin
            blink_reg <= 1'b0;
        end else if (bus.en_1hz) begin
            blink_reg <= ~blink_reg;
        end
    end

    generate
        for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_blank
            assign blank_mask_w[gi] = blink_reg && (edit_field_reg == 3'(gi));
        end
    endgenerate
`else
    assign blank_mask_w = 6'b0;
`endif

    assign bus.set_time    = set_time_reg;
    assign bus.bin_time    = bin_time_reg;
    assign bus.edit_active = edit_active_reg;
    assign bus.edit_field  = edit_field_reg;
    assign bus.edit_time   = edit_time_reg;
    assign bus.blank_mask  = blank_mask_w;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with DEBOUNCE_CYC=4, TIMEOUT_S=3.
module tb_time_set_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   set_cnt = 0;
    int   found;

    time_set_ctrl_if bus ();

    time_set_ctrl #(.DEBOUNCE_CYC(4), .TIMEOUT_S(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Count set_time cycles away from the active edge.
    always @(negedge clk) if (bus.set_time === 1'b1) set_cnt++;

    function automatic logic [47:0] pk(input int y, input int mo, input int d,
                                       input int h, input int mi, input int s);
        return {8'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] keys);
        @(negedge clk) bus.sw_in = keys;
        repeat (12) @(negedge clk);
        bus.sw_in = 4'b0000;
        repeat (12) @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk) bus.en_1hz = 1'b1;
        @(negedge clk) bus.en_1hz = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.en_1hz   = 1'b0;
        bus.sw_in    = 4'b0000;
        bus.cur_time = pk(23, 5, 10, 12, 30, 45);
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_set_time",    48'(bus.set_time),    48'd0);
        chk("rst_edit_active", 48'(bus.edit_active), 48'd0);
        chk("rst_edit_field",  48'(bus.edit_field),  48'd7);
        chk("rst_blank_mask",  48'(bus.blank_mask),  48'd0);
        chk("rst_bin_time",    bus.bin_time,         pk(0, 1, 1, 0, 0, 0));
        chk("rst_edit_time",   bus.edit_time,        pk(0, 1, 1, 0, 0, 0));
        rst = 1'b0;
        repeat (3) @(negedge clk);
        $display("step reset: done");

        // Enter edit, then bouncing UP gives a single increment
        press(4'b0001);
        chk("snap_field",  48'(bus.edit_field),  48'd0);
        chk("snap_active", 48'(bus.edit_active), 48'd1);
        chk("snap_time",   bus.edit_time,        pk(23, 5, 10, 12, 30, 45));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk) bus.sw_in = ((i / 2) % 2 == 0) ? 4'b0010 : 4'b0000;
        end
        press(4'b0010);
        chk("bounce_year", bus.edit_time, pk(24, 5, 10, 12, 30, 45));
        press(4'b1000);
        chk("bounce_commit_bin", bus.bin_time, pk(24, 5, 10, 12, 30, 45));
        chk("bounce_set_cnt", 48'(set_cnt), 48'd1);
        $display("step bounce: edit_time=%h", bus.edit_time);

        // Month wrap Jan->Feb clamps day 31 -> 28 (non-leap)
        bus.cur_time = pk(23, 1, 31, 8, 0, 0);
        press(4'b0001);
        press(4'b0001);
        chk("clamp28_field", 48'(bus.edit_field), 48'd1);
        press(4'b0010);
        chk("clamp28_time", bus.edit_time, pk(23, 2, 28, 8, 0, 0));
        press(4'b1000);
        chk("clamp28_bin", bus.bin_time, pk(23, 2, 28, 8, 0, 0));
        $display("step clamp28: bin_time=%h", bus.bin_time);

        // Leap year clamps to 29; DOWN back to January keeps 29
        bus.cur_time = pk(24, 1, 31, 8, 0, 0);
        press(4'b0001);
        press(4'b0001);
        press(4'b0010);
        chk("clamp29_time", bus.edit_time, pk(24, 2, 29, 8, 0, 0));
        press(4'b0100);
        chk("down_month", bus.edit_time, pk(24, 1, 29, 8, 0, 0));
        press(4'b0100);
        chk("down_wrap_month", bus.edit_time, pk(24, 12, 29, 8, 0, 0));
        press(4'b1000);
        chk("clamp29_set_cnt", 48'(set_cnt), 48'd3);
        $display("step clamp29: bin_time=%h", bus.bin_time);

        // Commit: year 99 wraps to 0, strobe timing and width
        bus.cur_time = pk(99, 6, 15, 1, 2, 3);
        press(4'b0001);
        press(4'b0010);
        chk("wrap_year", bus.edit_time, pk(0, 6, 15, 1, 2, 3));
        @(negedge clk) bus.sw_in = 4'b1000;
        found = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.set_time === 1'b1) begin
                found = i;
                break;
            end
        end
        chk("commit_latency", 48'(found), 48'd7);
        chk("commit_bin", bus.bin_time, pk(0, 6, 15, 1, 2, 3));
        chk("commit_field_during", 48'(bus.edit_field), 48'd0);
        @(negedge clk);
        chk("commit_width", 48'(bus.set_time), 48'd0);
        chk("commit_field_after", 48'(bus.edit_field), 48'd7);
        chk("commit_active_after", 48'(bus.edit_active), 48'd0);
        bus.sw_in = 4'b0000;
        repeat (12) @(negedge clk);
        chk("commit_set_cnt", 48'(set_cnt), 48'd4);
        $display("step commit: found=%0d bin_time=%h", found, bus.bin_time);

        // Priority: OK+UP together in SEL_HR commits without incrementing
        bus.cur_time = pk(10, 3, 4, 23, 0, 0);
        repeat (4) press(4'b0001);
        chk("prio_field", 48'(bus.edit_field), 48'd3);
        press(4'b1010);
        chk("prio_bin", bus.bin_time, pk(10, 3, 4, 23, 0, 0));
        chk("prio_set_cnt", 48'(set_cnt), 48'd5);
        chk("prio_field_after", 48'(bus.edit_field), 48'd7);
        $display("step priority: bin_time=%h", bus.bin_time);

        // Timeout after 3 idle ticks, no strobe
        press(4'b0001);
        tick();
        tick();
        chk("tmo_still_active", 48'(bus.edit_active), 48'd1);
        tick();
        chk("tmo_active", 48'(bus.edit_active), 48'd0);
        chk("tmo_field", 48'(bus.edit_field), 48'd7);
        chk("tmo_set_cnt", 48'(set_cnt), 48'd5);
        $display("step timeout: edit_active=%0b", bus.edit_active);

        // Blink on SEL_DY
        repeat (3) press(4'b0001);
        chk("blink_field", 48'(bus.edit_field), 48'd2);
        chk("blink_mask0", 48'(bus.blank_mask), 48'd0);
        @(negedge clk) bus.en_1hz = 1'b1;
        @(negedge clk) bus.en_1hz = 1'b0;
`ifdef TSC_BLINK_EN
        chk("blink_mask1", 48'(bus.blank_mask), 48'b000100);
`else
        chk("blink_mask1", 48'(bus.blank_mask), 48'd0);
`endif
        @(negedge clk) bus.en_1hz = 1'b1;
        @(negedge clk) bus.en_1hz = 1'b0;
        chk("blink_mask2", 48'(bus.blank_mask), 48'd0);
        $display("step blink: blank_mask=%b", bus.blank_mask);

        // Reset during SEL_MI
        repeat (2) press(4'b0001);
        chk("rmid_field", 48'(bus.edit_field), 48'd4);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("rmid_active", 48'(bus.edit_active), 48'd0);
        chk("rmid_field7", 48'(bus.edit_field),  48'd7);
        chk("rmid_bin",    bus.bin_time,         pk(0, 1, 1, 0, 0, 0));
        chk("rmid_edit",   bus.edit_time,        pk(0, 1, 1, 0, 0, 0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("rmid_set_cnt", 48'(set_cnt), 48'd5);
        chk("rmid_field_after", 48'(bus.edit_field), 48'd7);
        $display("step reset_mid: edit_field=%0d", bus.edit_field);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
